// File: rtl/trap_pkg.sv
// trap_pkg: shared constants, mstatus bit positions and FSM states for trap_ctrl.
package trap_pkg;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [31:0] INST_ECALL  = 32'h00000073;
  localparam logic [31:0] INST_MRET   = 32'h30200073;
  localparam int CAUSE_M_TIMER = 7;
  localparam int CAUSE_ECALL_M = 11;
  localparam int MS_MIE    = 3;
  localparam int MS_MPIE   = 7;
  localparam int MS_MPP_LO = 11;
  localparam int MS_MPP_HI = 12;
  localparam int MIE_MTIE  = 7;
  typedef enum logic [2:0] {
    S_IDLE, S_MEPC, S_MCAUSE, S_MSTATUS, S_MRET_MSTATUS, S_JUMP
  } state_e;
endpackage

// File: rtl/trap_ctrl.sv
// trap_ctrl: takes ECALL/MRET/timer-interrupt from decode, serialises the
// mepc/mcause/mstatus writes through one CSR port, then redirects the pipeline.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_valid_i,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] inst_addr_i,
  input  logic            timer_irq_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic [XLEN-1:0] mstatus_i,
  input  logic [XLEN-1:0] mie_i,
  output logic            csr_wen_o,
  output logic [11:0]     csr_waddr_o,
  output logic [XLEN-1:0] csr_wdata_o,
  output logic            hold_flag_o,
  output logic            intr_jump_en_o,
  output logic [XLEN-1:0] intr_jump_addr_o
);
  state_e          r_state, w_next;
  logic [XLEN-1:0] r_pc, r_mstatus, r_mtvec, r_mepc, r_cause;
  logic            r_is_intr, r_is_mret;
  logic            w_irq, w_ecall, w_mret, w_trig;
  logic [XLEN-1:0] w_ms_trap, w_ms_mret, w_base, w_target;
  logic            w_unused;

  assign w_unused = &{1'b0, mie_i[XLEN-1:MIE_MTIE+1], mie_i[MIE_MTIE-1:0]};
  assign w_irq    = inst_valid_i & timer_irq_i & mstatus_i[MS_MIE] & mie_i[MIE_MTIE];
  assign w_ecall  = inst_valid_i & (inst_i == INST_ECALL);
  assign w_mret   = inst_valid_i & (inst_i == INST_MRET);
  // gated by rst so hold_flag_o stays low while reset is asserted
  assign w_trig   = rst & (r_state == S_IDLE) & (w_irq | w_ecall | w_mret);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_mstatus <= '0;
      r_mtvec   <= '0;
      r_mepc    <= '0;
      r_cause   <= '0;
      r_is_intr <= 1'b0;
      r_is_mret <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_trig) begin
        r_pc      <= inst_addr_i;
        r_mstatus <= mstatus_i;
        r_mtvec   <= mtvec_i;
        r_mepc    <= mepc_i;
        r_cause   <= w_irq ? {1'b1, (XLEN-1)'(CAUSE_M_TIMER)} : XLEN'(CAUSE_ECALL_M);
        r_is_intr <= w_irq;
        r_is_mret <= !w_irq && !w_ecall;
      end
    end
  end

  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:         w_next = w_trig ? ((w_irq | w_ecall) ? S_MEPC : S_MRET_MSTATUS) : S_IDLE;
      S_MEPC:         w_next = S_MCAUSE;
      S_MCAUSE:       w_next = S_MSTATUS;
      S_MSTATUS:      w_next = S_JUMP;
      S_MRET_MSTATUS: w_next = S_JUMP;
      default:        w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_ms_trap                      = r_mstatus;
    w_ms_trap[MS_MPIE]             = r_mstatus[MS_MIE];
    w_ms_trap[MS_MIE]              = 1'b0;
    w_ms_trap[MS_MPP_HI:MS_MPP_LO] = 2'b11;
    w_ms_mret                      = r_mstatus;
    w_ms_mret[MS_MIE]              = r_mstatus[MS_MPIE];
    w_ms_mret[MS_MPIE]             = 1'b1;
    w_base   = {r_mtvec[XLEN-1:2], 2'b00};
    w_target = r_is_mret ? r_mepc :
               (VECTORED_EN && r_mtvec[1:0] == 2'b01 && r_is_intr) ?
               w_base + {{(XLEN-8){1'b0}}, r_cause[5:0], 2'b00} : w_base;
    csr_wen_o = (r_state == S_MEPC) | (r_state == S_MCAUSE) |
                (r_state == S_MSTATUS) | (r_state == S_MRET_MSTATUS);
    csr_waddr_o = (r_state == S_MEPC)   ? CSR_MEPC   :
                  (r_state == S_MCAUSE) ? CSR_MCAUSE :
                  csr_wen_o             ? CSR_MSTATUS : 12'h000;
    csr_wdata_o = (r_state == S_MEPC)         ? r_pc      :
                  (r_state == S_MCAUSE)       ? r_cause   :
                  (r_state == S_MSTATUS)      ? w_ms_trap :
                  (r_state == S_MRET_MSTATUS) ? w_ms_mret : '0;
    hold_flag_o      = (r_state != S_IDLE) | w_trig;
    intr_jump_en_o   = (r_state == S_JUMP);
    intr_jump_addr_o = intr_jump_en_o ? w_target : '0;
  end
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed checks of trap_ctrl sequences, with a second
// instance built in direct mode to compare vectored vs direct targets.
module tb_trap_ctrl;
  localparam logic [31:0] ECALL = 32'h00000073;
  localparam logic [31:0] MRET  = 32'h30200073;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inst_valid_i = 1'b0;
  logic [31:0] inst_i = '0;
  logic [63:0] inst_addr_i = '0;
  logic        timer_irq_i = 1'b0;
  logic [63:0] mtvec_i = '0, mepc_i = '0, mstatus_i = '0, mie_i = '0;
  logic        wen, hold, jen, wen_d, hold_d, jen_d;
  logic [11:0] waddr, waddr_d;
  logic [63:0] wdata, jaddr, wdata_d, jaddr_d;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  trap_ctrl #(.XLEN(64), .VECTORED_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .inst_valid_i(inst_valid_i), .inst_i(inst_i),
    .inst_addr_i(inst_addr_i), .timer_irq_i(timer_irq_i), .mtvec_i(mtvec_i),
    .mepc_i(mepc_i), .mstatus_i(mstatus_i), .mie_i(mie_i),
    .csr_wen_o(wen), .csr_waddr_o(waddr), .csr_wdata_o(wdata),
    .hold_flag_o(hold), .intr_jump_en_o(jen), .intr_jump_addr_o(jaddr));

  trap_ctrl #(.XLEN(64), .VECTORED_EN(1'b0)) dut_d (
    .clk(clk), .rst(rst), .inst_valid_i(inst_valid_i), .inst_i(inst_i),
    .inst_addr_i(inst_addr_i), .timer_irq_i(timer_irq_i), .mtvec_i(mtvec_i),
    .mepc_i(mepc_i), .mstatus_i(mstatus_i), .mie_i(mie_i),
    .csr_wen_o(wen_d), .csr_waddr_o(waddr_d), .csr_wdata_o(wdata_d),
    .hold_flag_o(hold_d), .intr_jump_en_o(jen_d), .intr_jump_addr_o(jaddr_d));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_wen, input logic [11:0] e_addr,
                         input logic [63:0] e_data, input logic e_hold,
                         input logic e_jen, input logic [63:0] e_jaddr);
    #1;
    chk({tag, ".wen"},   64'(wen),   64'(e_wen));
    chk({tag, ".waddr"}, 64'(waddr), 64'(e_addr));
    chk({tag, ".wdata"}, wdata,      e_data);
    chk({tag, ".hold"},  64'(hold),  64'(e_hold));
    chk({tag, ".jen"},   64'(jen),   64'(e_jen));
    chk({tag, ".jaddr"}, jaddr,      e_jaddr);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // reset state, even with an ECALL presented
    inst_valid_i = 1'b1; inst_i = ECALL; inst_addr_i = 64'h8000_0010;
    chk_all("reset", 0, 12'h0, 0, 0, 0, 0);
    tick();
    rst = 1'b1;
    // reset mid-sequence
    mstatus_i = 64'h8; mtvec_i = 64'h8000_1000;
    chk_all("rmid.T0", 0, 12'h0, 0, 1, 0, 0);
    tick(); inst_valid_i = 1'b0;
    chk_all("rmid.T1", 1, 12'h341, 64'h8000_0010, 1, 0, 0);
    tick();
    chk_all("rmid.T2", 1, 12'h342, 64'd11, 1, 0, 0);
    rst = 1'b0;
    chk_all("rmid.async", 0, 12'h0, 0, 0, 0, 0);
    tick(); tick();
    rst = 1'b1;
    chk_all("rmid.rel", 0, 12'h0, 0, 0, 0, 0);
    tick();
    chk_all("rmid.idle1", 0, 12'h0, 0, 0, 0, 0);
    tick();
    chk_all("rmid.idle2", 0, 12'h0, 0, 0, 0, 0);
    // ECALL trap
    inst_valid_i = 1'b1; inst_i = ECALL; inst_addr_i = 64'h8000_0010;
    chk_all("ecall.T0", 0, 12'h0, 0, 1, 0, 0);
    tick(); inst_valid_i = 1'b0;
    chk_all("ecall.T1", 1, 12'h341, 64'h8000_0010, 1, 0, 0);
    tick();
    chk_all("ecall.T2", 1, 12'h342, 64'd11, 1, 0, 0);
    tick();
    chk_all("ecall.T3", 1, 12'h300, 64'h1880, 1, 0, 0);
    tick();
    chk_all("ecall.T4", 0, 12'h0, 0, 1, 1, 64'h8000_1000);
    tick();
    chk_all("ecall.idle", 0, 12'h0, 0, 0, 0, 0);
    // MRET
    inst_valid_i = 1'b1; inst_i = MRET; mepc_i = 64'h8000_0014; mstatus_i = 64'h80;
    chk_all("mret.T0", 0, 12'h0, 0, 1, 0, 0);
    tick(); inst_valid_i = 1'b0;
    chk_all("mret.T1", 1, 12'h300, 64'h88, 1, 0, 0);
    tick();
    chk_all("mret.T2", 0, 12'h0, 0, 1, 1, 64'h8000_0014);
    tick();
    chk_all("mret.idle", 0, 12'h0, 0, 0, 0, 0);
    // timer IRQ, vectored mtvec; CSR inputs and irq change mid-sequence
    inst_valid_i = 1'b1; inst_i = NOP; inst_addr_i = 64'h8000_0020;
    mtvec_i = 64'h8000_1001; mstatus_i = 64'h8; mie_i = 64'h80; timer_irq_i = 1'b1;
    chk_all("irq.T0", 0, 12'h0, 0, 1, 0, 0);
    tick(); inst_valid_i = 1'b0; mstatus_i = 64'h0; mtvec_i = 64'h0;
    chk_all("irq.T1", 1, 12'h341, 64'h8000_0020, 1, 0, 0);
    tick(); timer_irq_i = 1'b0;
    chk_all("irq.T2", 1, 12'h342, 64'h8000_0000_0000_0007, 1, 0, 0);
    chk("irq.d.cause", wdata_d, 64'h8000_0000_0000_0007);
    tick();
    chk_all("irq.T3", 1, 12'h300, 64'h1880, 1, 0, 0);
    tick();
    chk_all("irq.T4", 0, 12'h0, 0, 1, 1, 64'h8000_101C);
    chk("irq.d.jen", 64'(jen_d), 64'd1);
    chk("irq.d.jaddr", jaddr_d, 64'h8000_1000);
    tick();
    chk_all("irq.idle", 0, 12'h0, 0, 0, 0, 0);
    // masking: MIE=0, MTIE=0, inst_valid_i=0
    inst_valid_i = 1'b1; inst_i = NOP; timer_irq_i = 1'b1; mstatus_i = 64'h0; mie_i = 64'h80;
    chk_all("mask.mie", 0, 12'h0, 0, 0, 0, 0);
    mstatus_i = 64'h8; mie_i = 64'h0;
    chk_all("mask.mtie", 0, 12'h0, 0, 0, 0, 0);
    tick();
    chk_all("mask.mtie.t1", 0, 12'h0, 0, 0, 0, 0);
    inst_valid_i = 1'b0; mie_i = 64'h80;
    chk_all("mask.valid", 0, 12'h0, 0, 0, 0, 0);
    tick();
    chk_all("mask.valid.t1", 0, 12'h0, 0, 0, 0, 0);
    // IRQ + ECALL together; ECALL held through sequence, re-taken after S_JUMP
    inst_valid_i = 1'b1; inst_i = ECALL; inst_addr_i = 64'h8000_0040;
    mtvec_i = 64'h8000_1000; mstatus_i = 64'h8; timer_irq_i = 1'b1;
    chk_all("ovl.T0", 0, 12'h0, 0, 1, 0, 0);
    tick(); timer_irq_i = 1'b0;
    chk_all("ovl.T1", 1, 12'h341, 64'h8000_0040, 1, 0, 0);
    tick();
    chk_all("ovl.T2", 1, 12'h342, 64'h8000_0000_0000_0007, 1, 0, 0);
    tick();
    chk_all("ovl.T3", 1, 12'h300, 64'h1880, 1, 0, 0);
    tick();
    chk_all("ovl.T4", 0, 12'h0, 0, 1, 1, 64'h8000_1000);
    tick();
    chk_all("b2b.T0", 0, 12'h0, 0, 1, 0, 0);
    tick(); inst_valid_i = 1'b0;
    chk_all("b2b.T1", 1, 12'h341, 64'h8000_0040, 1, 0, 0);
    tick();
    chk_all("b2b.T2", 1, 12'h342, 64'd11, 1, 0, 0);
    tick(); tick(); tick();
    chk_all("b2b.idle", 0, 12'h0, 0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
